// File: rtl/pool_pkg.sv
// Shared types and helpers for the pooling sequencer: FSM states, mode encodings
// and the configuration legality check applied when a job starts.
package pool_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2
  } pool_state_e;

  localparam logic MODE_MAX = 1'b0;
  localparam logic MODE_AVG = 1'b1;

  // A zero kernel, stride, window count or channel count would never terminate the walk.
  function automatic logic cfg_legal(input logic [31:0] k, input logic [31:0] s,
                                     input logic [31:0] w, input logic [31:0] c);
    return (k != 32'd0) && (s != 32'd0) && (w != 32'd0) && (c != 32'd0);
  endfunction

endpackage

// File: rtl/pool_index_counter.sv
// Nested kx/ky/window/channel counter for the pooling walk. Flags describe the
// current (pre-advance) position; the counters step only on an accepted beat.
module pool_index_counter #(
  parameter int KDIM_W = 3,
  parameter int WIN_W  = 4,
  parameter int CH_W   = 5
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_beat,
  input  logic              i_clear,
  input  logic [KDIM_W-1:0] i_kdim,
  input  logic [KDIM_W-1:0] i_stride,
  input  logic [WIN_W-1:0]  i_win,
  input  logic [CH_W-1:0]   i_ch,
  output logic [KDIM_W-1:0] o_kx,
  output logic [KDIM_W-1:0] o_ky,
  output logic [WIN_W-1:0]  o_win_idx,
  output logic [CH_W-1:0]   o_ch_idx,
  output logic              o_first,
  output logic              o_last,
  output logic              o_final
);

  logic [KDIM_W-1:0] r_kx, r_ky;
  logic [WIN_W-1:0]  r_win_idx;
  logic [CH_W-1:0]   r_ch_idx;
  logic [KDIM_W-1:0] w_kmax;
  logic              w_kx_end, w_ky_end, w_win_end, w_period_end;
  logic [WIN_W:0]    w_win_sum;

  assign w_kmax       = i_kdim - 1'b1;
  assign w_kx_end     = (r_kx == w_kmax);
  assign w_ky_end     = (r_ky == w_kmax);
  assign w_win_end    = w_kx_end & w_ky_end;
  // One extra bit so win_idx + S cannot wrap before the compare against W.
  assign w_win_sum    = {1'b0, r_win_idx} + (WIN_W+1)'(i_stride);
  assign w_period_end = w_win_end & (w_win_sum >= {1'b0, i_win});

  assign o_kx      = r_kx;
  assign o_ky      = r_ky;
  assign o_win_idx = r_win_idx;
  assign o_ch_idx  = r_ch_idx;
  assign o_first   = (r_kx == '0) & (r_ky == '0);
  assign o_last    = w_win_end;
  assign o_final   = w_period_end & (r_ch_idx == i_ch - 1'b1);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_kx      <= '0;
      r_ky      <= '0;
      r_win_idx <= '0;
      r_ch_idx  <= '0;
    end else if (i_clear) begin
      r_kx      <= '0;
      r_ky      <= '0;
      r_win_idx <= '0;
      r_ch_idx  <= '0;
    end else if (i_beat) begin
      if (w_kx_end) begin
        r_kx <= '0;
        r_ky <= w_ky_end ? '0 : r_ky + 1'b1;
      end else begin
        r_kx <= r_kx + 1'b1;
      end
      if (w_win_end) begin
        if (w_period_end) begin
          r_win_idx <= '0;
          r_ch_idx  <= r_ch_idx + 1'b1;
        end else begin
          r_win_idx <= w_win_sum[WIN_W-1:0];
        end
      end
    end
  end

endmodule

// File: rtl/pooling_sequencer.sv
// Pooling window sequencer: latches a job configuration on start, walks the
// K x K windows per channel under valid/ready, and drives registered strobes.
module pooling_sequencer
  import pool_pkg::*;
#(
  parameter int COLS   = 4,
  parameter int KDIM_W = 3,
  parameter int WIN_W  = 4,
  parameter int CH_W   = 5
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                cfg_en,
  input  logic [KDIM_W-1:0]   cfg_kdim,
  input  logic [KDIM_W-1:0]   cfg_stride,
  input  logic [WIN_W-1:0]    cfg_win,
  input  logic [CH_W-1:0]     cfg_ch,
  input  logic                cfg_mode,
  input  logic                start,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic                out_ready,
  output logic [COLS-1:0]     pool_valid_o,
  output logic [COLS-1:0]     pool_first_o,
  output logic [COLS-1:0]     pool_last_o,
  output logic [KDIM_W-1:0]   kx_o,
  output logic [KDIM_W-1:0]   ky_o,
  output logic [WIN_W-1:0]    win_idx_o,
  output logic [CH_W-1:0]     ch_idx_o,
  output logic                mode_o,
  output logic [2*KDIM_W-1:0] div_o,
  output logic                busy,
  output logic                done,
  output logic                cfg_err
);

  pool_state_e       r_state, w_next;
  logic [KDIM_W-1:0] r_kdim, r_stride;
  logic [WIN_W-1:0]  r_win;
  logic [CH_W-1:0]   r_ch;
  logic              r_mode, r_cfg_err;
  logic [2*KDIM_W-1:0] r_div;
  logic              w_cfg_ok, w_accept, w_beat, w_clear;
  logic [KDIM_W-1:0] w_kx, w_ky;
  logic [WIN_W-1:0]  w_win_idx;
  logic [CH_W-1:0]   w_ch_idx;
  logic              w_first, w_last, w_final;

  assign w_cfg_ok = cfg_legal(32'(cfg_kdim), 32'(cfg_stride), 32'(cfg_win), 32'(cfg_ch));
  assign w_accept = (r_state == IDLE) & start & cfg_en & w_cfg_ok;
  assign in_ready = (r_state == RUN) & out_ready;
  // A handshake during the abort cycle is discarded so no strobe follows it.
  assign w_beat   = in_valid & in_ready & cfg_en;
  assign w_clear  = (r_state != RUN) | ~cfg_en;
  assign busy     = (r_state != IDLE);
  assign done     = (r_state == DRAIN) & cfg_en;
  assign cfg_err  = r_cfg_err;
  assign mode_o   = r_mode;
  assign div_o    = r_div;

  pool_index_counter #(
    .KDIM_W (KDIM_W),
    .WIN_W  (WIN_W),
    .CH_W   (CH_W)
  ) u_counter (
    .clk       (clk),
    .rst       (rst),
    .i_beat    (w_beat),
    .i_clear   (w_clear),
    .i_kdim    (r_kdim),
    .i_stride  (r_stride),
    .i_win     (r_win),
    .i_ch      (r_ch),
    .o_kx      (w_kx),
    .o_ky      (w_ky),
    .o_win_idx (w_win_idx),
    .o_ch_idx  (w_ch_idx),
    .o_first   (w_first),
    .o_last    (w_last),
    .o_final   (w_final)
  );

  always_comb begin
    w_next = r_state;
    if (!cfg_en) begin
      w_next = IDLE;
    end else begin
      case (r_state)
        IDLE:    if (w_accept) w_next = RUN;
        RUN:     if (w_beat && w_final) w_next = DRAIN;
        DRAIN:   w_next = IDLE;
        default: w_next = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state   <= IDLE;
      r_cfg_err <= 1'b0;
    end else begin
      r_state   <= w_next;
      r_cfg_err <= (r_state == IDLE) & start & cfg_en & ~w_cfg_ok;
    end
  end

  // Configuration is captured only when a job is accepted; later cfg_* edits are ignored.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_kdim   <= '0;
      r_stride <= '0;
      r_win    <= '0;
      r_ch     <= '0;
      r_mode   <= MODE_MAX;
      r_div    <= '0;
    end else if (w_accept) begin
      r_kdim   <= cfg_kdim;
      r_stride <= cfg_stride;
      r_win    <= cfg_win;
      r_ch     <= cfg_ch;
      r_mode   <= cfg_mode;
      r_div    <= (2*KDIM_W)'(cfg_kdim) * (2*KDIM_W)'(cfg_kdim);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pool_valid_o <= '0;
      pool_first_o <= '0;
      pool_last_o  <= '0;
      kx_o         <= '0;
      ky_o         <= '0;
      win_idx_o    <= '0;
      ch_idx_o     <= '0;
    end else if (w_beat) begin
      pool_valid_o <= '1;
      pool_first_o <= {COLS{w_first}};
      pool_last_o  <= {COLS{w_last}};
      kx_o         <= w_kx;
      ky_o         <= w_ky;
      win_idx_o    <= w_win_idx;
      ch_idx_o     <= w_ch_idx;
    end else begin
      pool_valid_o <= '0;
      pool_first_o <= '0;
      pool_last_o  <= '0;
      kx_o         <= '0;
      ky_o         <= '0;
      win_idx_o    <= '0;
      ch_idx_o     <= '0;
    end
  end

endmodule

// File: tb/tb_pooling_sequencer.sv
// Directed bench for pooling_sequencer: runs hand-picked jobs and compares every
// strobe, handshake and status pulse against an expected walk built in the bench.
module tb_pooling_sequencer;
  import pool_pkg::*;

  logic       clk, rst, cfg_en, cfg_mode, start, in_valid, in_ready, out_ready;
  logic [2:0] cfg_kdim, cfg_stride, kx_o, ky_o;
  logic [3:0] cfg_win, win_idx_o;
  logic [4:0] cfg_ch, ch_idx_o;
  logic [3:0] pool_valid_o, pool_first_o, pool_last_o;
  logic       mode_o, busy, done, cfg_err;
  logic [5:0] div_o;

  int assertCount = 0;
  int failCount   = 0;
  logic [22:0] expQ[$];

  pooling_sequencer dut (
    .clk(clk), .rst(rst), .cfg_en(cfg_en), .cfg_kdim(cfg_kdim), .cfg_stride(cfg_stride),
    .cfg_win(cfg_win), .cfg_ch(cfg_ch), .cfg_mode(cfg_mode), .start(start),
    .in_valid(in_valid), .in_ready(in_ready), .out_ready(out_ready),
    .pool_valid_o(pool_valid_o), .pool_first_o(pool_first_o), .pool_last_o(pool_last_o),
    .kx_o(kx_o), .ky_o(ky_o), .win_idx_o(win_idx_o), .ch_idx_o(ch_idx_o),
    .mode_o(mode_o), .div_o(div_o), .busy(busy), .done(done), .cfg_err(cfg_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    assertCount++;
    if (observed !== expected) begin
      failCount++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", tag, observed, expected, $time);
    end
  endtask

  function automatic logic [31:0] packedStrobe();
    return 32'({pool_first_o, pool_last_o, ch_idx_o, win_idx_o, ky_o, kx_o});
  endfunction

  // Expected strobe sequence in walk order: channel, window, row, column.
  function automatic void buildExpected(input int k, input int s, input int w, input int c);
    logic f, l;
    expQ.delete();
    for (int ch = 0; ch < c; ch++)
      for (int win = 0; win < w; win += s)
        for (int ky = 0; ky < k; ky++)
          for (int kx = 0; kx < k; kx++) begin
            f = (kx == 0) && (ky == 0);
            l = (kx == k - 1) && (ky == k - 1);
            expQ.push_back({{4{f}}, {4{l}}, 5'(ch), 4'(win), 3'(ky), 3'(kx)});
          end
  endfunction

  // Called on a negedge; returns on the first negedge after the start pulse.
  task automatic applyStimulus(input int k, input int s, input int w, input int c, input logic mode);
    cfg_kdim   = 3'(k);
    cfg_stride = 3'(s);
    cfg_win    = 4'(w);
    cfg_ch     = 5'(c);
    cfg_mode   = mode;
    start      = 1'b1;
    @(negedge clk);
    start      = 1'b0;
    cfg_kdim   = 3'd7;
    cfg_stride = 3'd7;
    cfg_win    = 4'd15;
    cfg_ch     = 5'd31;
    cfg_mode   = ~mode;
  endtask

  task automatic runJob(input bit toggle, input int budget);
    int idx = 0, issued = 0, doneCnt = 0, cyc = 0;
    bit finished = 0;
    while (!finished && cyc < budget) begin
      if (pool_valid_o != 4'd0) begin
        if (idx < expQ.size()) checkOutput("strobe", packedStrobe(), 32'(expQ[idx]));
        else checkOutput("extra_strobe", 32'(idx), 32'(expQ.size()));
        checkOutput("valid_all", 32'(pool_valid_o), 32'hF);
        idx++;
      end
      if (done) begin
        doneCnt++;
        checkOutput("done_at_last", 32'(idx), 32'(expQ.size()));
        checkOutput("done_no_err", 32'(cfg_err), 32'd0);
        finished = 1;
      end
      out_ready = toggle ? cyc[0] : 1'b1;
      #1;
      checkOutput("in_ready", 32'(in_ready), 32'((issued < expQ.size()) && out_ready));
      if (in_valid && in_ready) issued++;
      cyc++;
      @(negedge clk);
    end
    if (!finished) checkOutput("timeout", 32'd0, 32'd1);
    checkOutput("done_count", 32'(doneCnt), 32'd1);
    checkOutput("idle_busy", 32'(busy), 32'd0);
    checkOutput("idle_done", 32'(done), 32'd0);
    checkOutput("idle_valid", 32'(pool_valid_o), 32'd0);
  endtask

  initial begin
    rst = 1'b1; cfg_en = 1'b0; cfg_mode = 1'b0; start = 1'b0;
    in_valid = 1'b0; out_ready = 1'b0;
    cfg_kdim = '0; cfg_stride = '0; cfg_win = '0; cfg_ch = '0;
    #3;
    checkOutput("rst_busy", 32'(busy), 32'd0);
    checkOutput("rst_in_ready", 32'(in_ready), 32'd0);
    checkOutput("rst_valid", 32'(pool_valid_o), 32'd0);
    checkOutput("rst_div", 32'(div_o), 32'd0);
    checkOutput("rst_mode", 32'(mode_o), 32'd0);
    checkOutput("rst_done", 32'(done), 32'd0);
    checkOutput("rst_cfg_err", 32'(cfg_err), 32'd0);
    cfg_en = 1'b1; out_ready = 1'b1; in_valid = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);

    $display("[TB] job K=2 S=2 W=4 C=1");
    buildExpected(2, 2, 4, 1);
    applyStimulus(2, 2, 4, 1, MODE_MAX);
    checkOutput("div_k2", 32'(div_o), 32'd4);
    checkOutput("mode_max", 32'(mode_o), 32'd0);
    runJob(1'b0, 100);

    $display("[TB] illegal start then K=1 S=1 W=3 C=2");
    applyStimulus(0, 1, 3, 2, MODE_MAX);
    checkOutput("cfg_err_pulse", 32'(cfg_err), 32'd1);
    checkOutput("cfg_err_busy", 32'(busy), 32'd0);
    @(negedge clk);
    checkOutput("cfg_err_clear", 32'(cfg_err), 32'd0);
    checkOutput("cfg_err_busy2", 32'(busy), 32'd0);
    buildExpected(1, 1, 3, 2);
    applyStimulus(1, 1, 3, 2, MODE_AVG);
    checkOutput("mode_avg", 32'(mode_o), 32'd1);
    checkOutput("div_k1", 32'(div_o), 32'd1);
    runJob(1'b0, 100);

    $display("[TB] job K=3 S=1 W=2 C=1 with out_ready toggling");
    buildExpected(3, 1, 2, 1);
    applyStimulus(3, 1, 2, 1, MODE_MAX);
    checkOutput("div_k3", 32'(div_o), 32'd9);
    runJob(1'b1, 200);

    $display("[TB] abort after five beats");
    out_ready = 1'b1;
    buildExpected(2, 2, 4, 1);
    applyStimulus(2, 2, 4, 1, MODE_MAX);
    repeat (5) @(negedge clk);
    checkOutput("abort_pre_strobe", packedStrobe(), 32'(expQ[4]));
    cfg_en = 1'b0;
    @(negedge clk);
    checkOutput("abort_busy", 32'(busy), 32'd0);
    checkOutput("abort_valid", 32'(pool_valid_o), 32'd0);
    checkOutput("abort_done", 32'(done), 32'd0);
    @(negedge clk);
    checkOutput("abort_done2", 32'(done), 32'd0);
    cfg_en = 1'b1;
    applyStimulus(2, 2, 4, 1, MODE_MAX);
    runJob(1'b0, 100);

    $display("[TB] async reset mid-run");
    buildExpected(3, 1, 2, 1);
    applyStimulus(3, 1, 2, 1, MODE_AVG);
    repeat (3) @(negedge clk);
    checkOutput("rst_pre_kx", 32'(kx_o), 32'd2);
    #2 rst = 1'b1;
    #1;
    checkOutput("rst_mid_busy", 32'(busy), 32'd0);
    checkOutput("rst_mid_valid", 32'(pool_valid_o), 32'd0);
    checkOutput("rst_mid_kx", 32'(kx_o), 32'd0);
    checkOutput("rst_mid_div", 32'(div_o), 32'd0);
    checkOutput("rst_mid_mode", 32'(mode_o), 32'd0);
    checkOutput("rst_mid_in_ready", 32'(in_ready), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    buildExpected(2, 1, 3, 1);
    applyStimulus(2, 1, 3, 1, MODE_AVG);
    checkOutput("post_rst_mode", 32'(mode_o), 32'd1);
    checkOutput("post_rst_div", 32'(div_o), 32'd4);
    runJob(1'b0, 100);

    $display("[TB] End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
    $finish;
  end

endmodule
